branch_predictor: RTL and testbench
===================================

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 The block SHALL have parameter ENTRIES, default 16, meaning the number of direct-mapped BTB entries (power of two, 2..256).
REQ-002 The block SHALL have parameter CTR_BITS, default 2, meaning the saturating-counter width per entry (1..4).
REQ-003 The block SHALL have parameter CNT_W, default 16, meaning the mispredict statistics counter width.
REQ-004 The block SHALL have port CLK, input, 1, meaning the single clock; all state changes on the rising edge.
REQ-005 The block SHALL have port nRST, input, 1, meaning a synchronous active-low reset sampled on the rising edge of CLK.
REQ-006 The block SHALL have port lookup_pc, input, 32, meaning the fetch-stage PC (cpc).
REQ-007 The block SHALL have port pred_hit, output, 1, meaning a valid entry whose tag matches lookup_pc.
REQ-008 The block SHALL have port pred_taken, output, 1, meaning predict taken (hit and counter MSB = 1).
REQ-009 The block SHALL have port pred_target, output, 32, meaning the stored target when pred_taken, else lookup_pc + 4.
REQ-010 The block SHALL have port upd_valid, input, 1, meaning a resolved branch/jump update this cycle; it is a single-cycle pulse qualified by the pipeline enable.
REQ-011 The block SHALL have port upd_pc, input, 32, meaning the PC of the resolved instruction.
REQ-012 The block SHALL have port upd_taken, input, 1, meaning the actual outcome.
REQ-013 The block SHALL have port upd_target, input, 32, meaning the actual target address.
REQ-014 The block SHALL have port upd_pred_taken, input, 1, meaning the prediction that was carried down the pipe for that instruction.
REQ-015 The block SHALL have port clear, input, 1, meaning invalidate all entries.
REQ-016 The block SHALL have port mispredict, output, 1, meaning a combinational flag that is 1 when upd_valid and upd_taken != upd_pred_taken.
REQ-017 The block SHALL have port mispredict_cnt, output, CNT_W, meaning the saturating count of mispredicts.

Function
REQ-018 Index SHALL be pc[IDX+1:2] with IDX = log2(ENTRIES); tag SHALL be pc[31:IDX+2]; pc[1:0] SHALL be ignored.
REQ-019 Each entry SHALL hold valid (1), tag (30-IDX), target (32) and ctr (CTR_BITS).
REQ-020 Lookup SHALL be purely combinational from lookup_pc and current state, with zero-cycle latency.
REQ-021 An update that hits (valid and tag match at the upd_pc index) SHALL set ctr to ctr+1 if upd_taken and to ctr-1 if not taken, saturating at 2^CTR_BITS-1 and 0.
REQ-022 An update that hits with upd_taken SHALL overwrite the target with upd_target.
REQ-023 An update that misses with upd_taken SHALL allocate the entry, replacing any entry at that index: valid=1, new tag, target=upd_target, ctr=2^(CTR_BITS-1) (weakly taken).
REQ-024 An update that misses with not-taken SHALL leave the table unchanged.
REQ-025 Update writes SHALL take effect at the next rising edge; a same-cycle lookup of the same index SHALL see the pre-update state (no write-through bypass).
REQ-026 When clear=1, all valid bits SHALL be 0 after the edge; clear SHALL take priority over a simultaneous upd_valid, which is dropped; ctr, target and mispredict_cnt SHALL be unaffected.
REQ-027 mispredict_cnt SHALL increment by 1 on each edge where mispredict=1 and SHALL hold at 2^CNT_W-1 without wrap.
REQ-028 mispredict SHALL still be counted when clear is asserted in the same cycle.
REQ-029 With upd_valid=0 the block SHALL change no state except through clear or reset.

Reset
REQ-030 While nRST=0 at a rising edge, all valid bits, all ctr fields and mispredict_cnt SHALL be cleared to 0; targets and tags need not be reset.
REQ-031 After reset, pred_hit=0, pred_taken=0 and pred_target=lookup_pc+4 for any lookup_pc.
REQ-032 Reset asserted mid-update SHALL win and the update SHALL be discarded.

Verification
REQ-033 Reset, then lookup_pc=0x0000_0040 -> pred_hit=0, pred_taken=0, pred_target=0x0000_0044.
REQ-034 Update pc=0x40, taken, target=0x100, pred_taken=0; next cycle lookup 0x40 -> hit=1, taken=1, target=0x100, mispredict_cnt=1.
REQ-035 With ENTRIES=16, after REQ-034, two not-taken updates at 0x40 -> ctr 2->1->0, lookup predicts not taken with target 0x44; a third not-taken update keeps ctr at 0.
REQ-036 Aliasing: entry for 0x40, then taken update at 0x80 (same index, different tag) -> lookup 0x40 misses and lookup 0x80 hits with the new target.
REQ-037 clear and a taken update at 0x40 in the same cycle -> next cycle lookup 0x40 misses; mispredict_cnt still increments if a mispredict was flagged.
REQ-038 With CNT_W=2, drive 5 mispredicts -> mispredict_cnt saturates at 3.

Source files
------------

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with per-entry saturating direction counters
// and a saturating mispredict statistics counter.
module branch_predictor #(
  parameter int ENTRIES  = 16,
  parameter int CTR_BITS = 2,
  parameter int CNT_W    = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [31:0]      lookup_pc,
  output logic             pred_hit,
  output logic             pred_taken,
  output logic [31:0]      pred_target,
  input  logic             upd_valid,
  input  logic [31:0]      upd_pc,
  input  logic             upd_taken,
  input  logic [31:0]      upd_target,
  input  logic             upd_pred_taken,
  input  logic             clear,
  output logic             mispredict,
  output logic [CNT_W-1:0] mispredict_cnt
);

  localparam int IDX   = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX;

  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
  localparam logic [CTR_BITS-1:0] CTR_ZERO = '0;
  localparam logic [CTR_BITS-1:0] CTR_ONE  = CTR_BITS'(1);
  localparam logic [CTR_BITS-1:0] CTR_WEAK = CTR_ONE << (CTR_BITS - 1);
  localparam logic [CNT_W-1:0]    CNT_MAX  = '1;
  localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(1);

  logic [ENTRIES-1:0]  valid_q;
  logic [TAG_W-1:0]    tag_q [ENTRIES];
  logic [31:0]         tgt_q [ENTRIES];
  logic [CTR_BITS-1:0] ctr_q [ENTRIES];
  logic [CNT_W-1:0]    cnt_q;

  logic [IDX-1:0]      lk_idx;
  logic [TAG_W-1:0]    lk_tag;
  logic [IDX-1:0]      u_idx;
  logic [TAG_W-1:0]    u_tag;
  logic                u_hit;
  logic [CTR_BITS-1:0] ctr_d;
  logic [CNT_W-1:0]    cnt_d;
  logic                unused_upd_pc_lo;

  function automatic logic [CTR_BITS-1:0] sat_inc(input logic [CTR_BITS-1:0] c);
    return (c == CTR_MAX) ? c : c + CTR_ONE;
  endfunction

  function automatic logic [CTR_BITS-1:0] sat_dec(input logic [CTR_BITS-1:0] c);
    return (c == CTR_ZERO) ? c : c - CTR_ONE;
  endfunction

  function automatic logic [CNT_W-1:0] sat_cnt(input logic [CNT_W-1:0] c, input logic inc);
    return (inc && c != CNT_MAX) ? c + CNT_ONE : c;
  endfunction

  assign lk_idx = lookup_pc[IDX+1:2];
  assign lk_tag = lookup_pc[31:IDX+2];
  assign u_idx  = upd_pc[IDX+1:2];
  assign u_tag  = upd_pc[31:IDX+2];
  assign unused_upd_pc_lo = ^upd_pc[1:0];

  // Lookup reads only registered state, so a same-cycle update is never bypassed.
  always_comb begin
    pred_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    pred_taken  = pred_hit && ctr_q[lk_idx][CTR_BITS-1];
    pred_target = pred_taken ? tgt_q[lk_idx] : lookup_pc + 32'd4;
  end

  always_comb begin
    u_hit      = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
    ctr_d      = upd_taken ? sat_inc(ctr_q[u_idx]) : sat_dec(ctr_q[u_idx]);
    mispredict = upd_valid && (upd_taken != upd_pred_taken);
    cnt_d      = sat_cnt(cnt_q, mispredict);
  end

  assign mispredict_cnt = cnt_q;

  // Tags and targets are never reset; they are meaningless while valid is low.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      valid_q <= '0;
      cnt_q   <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (clear) begin
        valid_q <= '0;
      end else if (upd_valid) begin
        if (u_hit) begin
          ctr_q[u_idx] <= ctr_d;
          if (upd_taken) tgt_q[u_idx] <= upd_target;
        end else if (upd_taken) begin
          valid_q[u_idx] <= 1'b1;
          tag_q[u_idx]   <= u_tag;
          tgt_q[u_idx]   <= upd_target;
          ctr_q[u_idx]   <= CTR_WEAK;
        end
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench: two predictor configurations share one stimulus stream and
// are compared against a word-address table model of the prediction rules.
module tb_branch_predictor;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic [31:0] lookup_pc = '0;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = '0;
  logic        upd_taken = 1'b0;
  logic [31:0] upd_target = '0;
  logic        upd_pred_taken = 1'b0;
  logic        clear = 1'b0;

  logic        hit0, tkn0, mp0, hit1, tkn1, mp1;
  logic [31:0] tgt0, tgt1;
  logic [15:0] cnt0;
  logic [1:0]  cnt1;

  branch_predictor #(.ENTRIES(16), .CTR_BITS(2), .CNT_W(16)) dut (
    .CLK(CLK), .nRST(nRST), .lookup_pc(lookup_pc),
    .pred_hit(hit0), .pred_taken(tkn0), .pred_target(tgt0),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
    .clear(clear), .mispredict(mp0), .mispredict_cnt(cnt0));

  branch_predictor #(.ENTRIES(4), .CTR_BITS(3), .CNT_W(2)) dut2 (
    .CLK(CLK), .nRST(nRST), .lookup_pc(lookup_pc),
    .pred_hit(hit1), .pred_taken(tkn1), .pred_target(tgt1),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
    .clear(clear), .mispredict(mp1), .mispredict_cnt(cnt1));

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic        hit;
    logic        taken;
    logic [31:0] tgt;
    logic        mp;
    logic [31:0] cnt;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  logic chk_valid = 1'b0;
  int   checks = 0;
  int   errors = 0;

  // Model: each slot remembers the full word address (pc>>2) it holds.
  int          m_ent[2]  = '{16, 4};
  int          m_cmax[2] = '{3, 7};
  int          m_nmax[2] = '{65535, 3};
  bit          m_valid[2][256];
  int unsigned m_word[2][256];
  logic [31:0] m_tgt[2][256];
  int          m_ctr[2][256];
  int          m_cnt[2];

  function automatic exp_t model_expect(int m);
    exp_t e;
    int   i;
    i       = int'((lookup_pc >> 2) % m_ent[m]);
    e.hit   = m_valid[m][i] && (m_word[m][i] == (lookup_pc >> 2));
    e.taken = e.hit && (m_ctr[m][i] >= (m_cmax[m] + 1) / 2);
    e.tgt   = e.taken ? m_tgt[m][i] : lookup_pc + 32'd4;
    e.mp    = upd_valid && (upd_taken != upd_pred_taken);
    e.cnt   = 32'(m_cnt[m]);
    return e;
  endfunction

  function automatic void model_edge(int m);
    int          i;
    int unsigned w;
    bit          mp;
    mp = upd_valid && (upd_taken != upd_pred_taken);
    if (!nRST) begin
      m_cnt[m] = 0;
      for (int k = 0; k < 256; k++) begin
        m_valid[m][k] = 0;
        m_ctr[m][k]   = 0;
      end
      return;
    end
    if (mp && m_cnt[m] < m_nmax[m]) m_cnt[m]++;
    if (clear) begin
      for (int k = 0; k < 256; k++) m_valid[m][k] = 0;
      return;
    end
    if (!upd_valid) return;
    w = upd_pc >> 2;
    i = int'(w % m_ent[m]);
    if (m_valid[m][i] && m_word[m][i] == w) begin
      if (upd_taken) begin
        if (m_ctr[m][i] < m_cmax[m]) m_ctr[m][i]++;
        m_tgt[m][i] = upd_target;
      end else if (m_ctr[m][i] > 0) begin
        m_ctr[m][i]--;
      end
    end else if (upd_taken) begin
      m_valid[m][i] = 1;
      m_word[m][i]  = w;
      m_tgt[m][i]   = upd_target;
      m_ctr[m][i]   = (m_cmax[m] + 1) / 2;
    end
  endfunction

  task automatic step(input logic rst_n, input logic clr, input logic uv,
                      input logic [31:0] upc, input logic ut, input logic [31:0] utgt,
                      input logic upt, input logic [31:0] lpc, input logic do_chk);
    nRST = rst_n; clear = clr; upd_valid = uv; upd_pc = upc; upd_taken = ut;
    upd_target = utgt; upd_pred_taken = upt; lookup_pc = lpc;
    chk_valid = do_chk;
    if (do_chk) begin
      q0.push_back(model_expect(0));
      q1.push_back(model_expect(1));
    end
    model_edge(0);
    model_edge(1);
    @(posedge CLK);
    #1;
  endtask

  task automatic look(input logic [31:0] lpc);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, lpc, 1'b1);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, req, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (chk_valid) begin
      if (q0.size() == 0 || q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_empty: got 0 entries expected >=1 at %0t", $time);
      end else begin
        exp_t e0, e1;
        e0 = q0.pop_front();
        e1 = q1.pop_front();
        chk("hit_a",    32'(hit0), 32'(e0.hit));
        chk("taken_a",  32'(tkn0), 32'(e0.taken));
        chk("target_a", tgt0,      e0.tgt);
        chk("misp_a",   32'(mp0),  32'(e0.mp));
        chk("cnt_a",    32'(cnt0), e0.cnt);
        chk("hit_b",    32'(hit1), 32'(e1.hit));
        chk("taken_b",  32'(tkn1), 32'(e1.taken));
        chk("target_b", tgt1,      e1.tgt);
        chk("misp_b",   32'(mp1),  32'(e1.mp));
        chk("cnt_b",    32'(cnt1), e1.cnt);
      end
    end
  end

  function automatic logic [31:0] rnd_pc();
    logic [31:0] p;
    p = (32'($urandom_range(0, 47)) << 2) | 32'($urandom_range(0, 3));
    if ($urandom_range(0, 7) == 0) p = p | 32'h8000_0000;
    return p;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    @(posedge CLK);
    #1;
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h40, 1'b0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h40, 1'b0);
    look(32'h40);
    // taken update with mispredict; same-cycle lookup must still miss
    step(1'b1, 1'b0, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'h40, 1'b1);
    look(32'h40);
    for (int k = 0; k < 3; k++)
      step(1'b1, 1'b0, 1'b1, 32'h40, 1'b0, 32'h0, 1'b1, 32'h40, 1'b1);
    look(32'h40);
    step(1'b1, 1'b0, 1'b1, 32'h40, 1'b1, 32'h104, 1'b0, 32'h40, 1'b1);
    step(1'b1, 1'b0, 1'b1, 32'h80, 1'b1, 32'h200, 1'b1, 32'h40, 1'b1);
    look(32'h40);
    look(32'h80);
    look(32'h43);
    step(1'b1, 1'b1, 1'b1, 32'h40, 1'b1, 32'h300, 1'b0, 32'h80, 1'b1);
    look(32'h40);
    look(32'h80);
    step(1'b1, 1'b0, 1'b1, 32'h40, 1'b1, 32'h400, 1'b0, 32'h40, 1'b1);
    step(1'b0, 1'b0, 1'b1, 32'h80, 1'b1, 32'h500, 1'b0, 32'h40, 1'b1);
    look(32'h40);
    look(32'h80);
    for (int k = 0; k < 5; k++)
      step(1'b1, 1'b0, 1'b1, 32'h300, 1'b0, 32'h0, 1'b1, 32'h300, 1'b1);
    look(32'h300);
    for (int n = 0; n < 3000; n++) begin
      logic rst_n, clr, uv, ut, upt;
      rst_n = ($urandom_range(0, 99) >= 2);
      clr   = ($urandom_range(0, 99) < 3);
      uv    = ($urandom_range(0, 99) < 60);
      ut    = ($urandom_range(0, 99) < 65);
      upt   = 1'($urandom_range(0, 1));
      step(rst_n, clr, uv, rnd_pc(), ut, $urandom & 32'hFFFF_FFFC, upt, rnd_pc(), 1'b1);
    end
    chk_valid = 1'b0;
    repeat (2) @(posedge CLK);
    chk("scoreboard_drained", 32'(q0.size() + q1.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
